// File: rtl/uart_rx_controller_pkg.sv
// uart_pkg: shared receive-state encoding, default sizes, parity helper.
// Imported by the UART receive controller, its interface and bench.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  localparam int UART_WORD_SIZE  = 8;
  localparam int UART_OVERSAMPLE = 16;

  // Expected parity bit for up to 9 data bits; odd=1 inverts.
  function automatic logic parity_bit(
    input logic [8:0] data,
    input logic       odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// Receive-buffer link: DataOut/SetFlag load strobe out, Flag (full) in.
// master = controller side, slave = buffer side.
interface uart_rx_controller_if #(
  parameter int WORD_SIZE = uart_pkg::UART_WORD_SIZE
);

  logic [WORD_SIZE-1:0] DataOut;
  logic                 SetFlag;
  logic                 Flag;

  modport master (
    output DataOut,
    output SetFlag,
    input  Flag
  );

  modport slave (
    input  DataOut,
    input  SetFlag,
    output Flag
  );

endinterface

// File: rtl/uart_rx_controller_sync.sv
// uart_rx_sync: 2-flop synchronizer, reset value 1 (idle-high lines).
// Ports: Clock, ResetN (sync, active-low), d (async in), q (synced out).
module uart_rx_sync (
  input  logic Clock,
  input  logic ResetN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: oversampled UART receiver FSM feeding a rx buffer.
// Ports: Clock, ResetN (sync, active-low), BaudTick, SerialIn,
//   ClearErrors, rx_buf (DataOut/SetFlag/Flag), Busy,
//   FramingError, OverrunError, ParityError.
// Option: define UART_RX_PARITY_EN to add a parity bit before stop.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int WORD_SIZE  = UART_WORD_SIZE,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                        Clock,
  input  logic                        ResetN,
  input  logic                        BaudTick,
  input  logic                        SerialIn,
  input  logic                        ClearErrors,
  uart_rx_controller_if.master        rx_buf,
  output logic                        Busy,
  output logic                        FramingError,
  output logic                        OverrunError,
  output logic                        ParityError
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WORD_SIZE);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
  localparam logic      ODD        = (PARITY_ODD != 0);
  logic par_err;
  assign ParityError = par_err;
`else
  localparam rx_state_t AFTER_DATA = STOP;
  logic unused_par;
  assign unused_par  = (PARITY_ODD != 0);
  assign ParityError = 1'b0;
`endif

  rx_state_t            state;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bitcnt;
  logic [WORD_SIZE-1:0] shreg;
  logic                 rxs;

  uart_rx_sync u_sync (
    .Clock  (Clock),
    .ResetN (ResetN),
    .d      (SerialIn),
    .q      (rxs)
  );

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state          <= IDLE;
      tick           <= '0;
      bitcnt         <= '0;
      shreg          <= '0;
      rx_buf.DataOut <= '0;
      rx_buf.SetFlag <= 1'b0;
      FramingError   <= 1'b0;
      OverrunError   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err        <= 1'b0;
`endif
    end else begin
      rx_buf.SetFlag <= 1'b0;
      // Clear first so a same-cycle error set below wins.
      if (ClearErrors) begin
        FramingError <= 1'b0;
        OverrunError <= 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err      <= 1'b0;
`endif
      end
      if (BaudTick) begin
        unique case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              tick  <= '0;
            end
          end
          START: begin
            if (tick == TICK_MID) begin
              tick   <= '0;
              bitcnt <= '0;
              state  <= rxs ? IDLE : DATA;
            end else begin
              tick <= tick + 1'b1;
            end
          end
          DATA: begin
            if (tick == TICK_LAST) begin
              tick  <= '0;
              shreg <= {rxs, shreg[WORD_SIZE-1:1]};
              if (bitcnt == BIT_LAST) begin
                bitcnt <= '0;
                state  <= AFTER_DATA;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
          PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (tick == TICK_LAST) begin
              tick  <= '0;
              state <= STOP;
              if (rxs != parity_bit(9'(shreg), ODD))
                par_err <= 1'b1;
            end else begin
              tick <= tick + 1'b1;
            end
`else
            state <= IDLE;
`endif
          end
          STOP: begin
            if (tick == TICK_LAST) begin
              tick <= '0;
              if (rxs) begin
                rx_buf.DataOut <= shreg;
                rx_buf.SetFlag <= 1'b1;
                if (rx_buf.Flag)
                  OverrunError <= 1'b1;
                state <= IDLE;
              end else begin
                FramingError <= 1'b1;
                state        <= BREAK_WAIT;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
          BREAK_WAIT: begin
            // Wait out a held-low line so it cannot retrigger.
            if (rxs)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
